// File: rtl/alu_mdu.sv
// MIPS datapath ALU with an iterative radix-2 multiply/divide unit and HI/LO registers.
// Single-cycle ops are purely combinational; mult/div take WIDTH cycles behind a start/busy/done handshake.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  input  logic             start,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  // ---------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             lt_unsigned;

  assign sum         = srca + srcb;
  assign diff        = srca - srcb;
  assign lt_signed   = $signed(srca) < $signed(srcb);
  assign lt_unsigned = srca < srcb;

  always_comb begin
    aluout   = '0;
    overflow = 1'b0;
    case (alucontrol)
      4'b0000: begin
        aluout   = sum;
        overflow = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
      end
      4'b0001: begin
        aluout   = diff;
        overflow = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
      end
      4'b0010: aluout = srca & srcb;
      4'b0011: aluout = srca | srcb;
      4'b0100: aluout = {{(WIDTH-1){1'b0}}, lt_signed};
      4'b0101: aluout = {{(WIDTH-1){1'b0}}, lt_unsigned};
      4'b0110: aluout = srca ^ srcb;
      4'b0111: aluout = ~(srca | srcb);
      4'b1000: aluout = hi;
      4'b1001: aluout = lo;
      default: aluout = '0;
    endcase
  end

  assign zero = ~|aluout;

  // ---------------------------------------------------------------
  // Multiply/divide launch decode
  // ---------------------------------------------------------------
  logic             md_op;
  logic             accept;
  logic             is_signed;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign md_op     = (alucontrol >= 4'b1010) && (alucontrol <= 4'b1101);
  assign accept    = (state == IDLE) && start && md_op;
  assign is_div    = alucontrol[2];
  assign is_signed = ~alucontrol[0];
  assign sign_a    = is_signed & srca[WIDTH-1];
  assign sign_b    = is_signed & srcb[WIDTH-1];
  assign mag_a     = sign_a ? (~srca + 1'b1) : srca;
  assign mag_b     = sign_b ? (~srcb + 1'b1) : srcb;

  // ---------------------------------------------------------------
  // One radix-2 iteration
  // ---------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // Shift-add: acc_lo holds the multiplier, consumed LSB first.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Restoring division: acc_hi is the partial remainder, acc_lo the dividend/quotient.
  // The remainder stays below the divisor, so the W-bit subtraction cannot lose bits.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, operand};
  assign div_hi    = div_ge ? (div_shift[WIDTH-1:0] - operand) : div_shift[WIDTH-1:0];
  assign div_lo    = {acc_lo[WIDTH-2:0], div_ge};

  assign step_hi = op_div ? div_hi : mul_hi;
  assign step_lo = op_div ? div_lo : mul_lo;

  // Sign fix-up applied on the final edge.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last;

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign quo_fix  = (neg_q && !div_zero) ? (~step_lo + 1'b1) : step_lo;
  assign rem_fix  = neg_r ? (~step_hi + 1'b1) : step_hi;
  assign last     = (state == RUN) && (cnt == '0);

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        cnt      <= CW'(WIDTH - 1);
        acc_hi   <= '0;
        acc_lo   <= is_div ? mag_a : mag_b;
        operand  <= is_div ? mag_b : mag_a;
        op_div   <= is_div;
        neg_q    <= sign_a ^ sign_b;
        neg_r    <= sign_a;
        div_zero <= (srcb == '0);
      end else if (state == RUN) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: combinational ALU checks plus a scoreboard of expected HI/LO results
// pushed at each multiply/divide launch and popped when done pulses.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alucontrol;
  logic        start;
  logic [31:0] aluout;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .start      (start),
    .aluout     (aluout),
    .zero       (zero),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    case (op)
      4'b1010: begin q = sa * sbv; return q; end
      4'b1011: return ua * ub;
      4'b1100: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      4'b1101: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input logic exp_zero, input logic exp_ovf);
    alucontrol = op;
    srca       = a;
    srcb       = b;
    #1;
    chk({tag, "_out"}, aluout, exp_out);
    chk({tag, "_zero"}, zero, exp_zero);
    chk({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    srca       = a;
    srcb       = b;
    alucontrol = op;
    start      = 1'b1;
    sb_q.push_back(model(op, a, b));
  endtask

  // Called at the negedge where start is high; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input int poke);
    int          cycles   = 0;
    int          busy_cnt = 0;
    logic        seen     = 1'b0;
    logic [63:0] e;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_cnt = 1;
    while (cycles < 40 && !seen) begin
      start = 1'b0;
      if (cycles == poke) begin
        start      = 1'b1;
        alucontrol = 4'b1101;
        srca       = $urandom;
        srcb       = $urandom | 32'd1;
      end
      if (cycles == 3) begin
        alucontrol = 4'b1001;
        #1 chk({tag, "_mflo_busy"}, aluout, cur_lo);
        alucontrol = 4'b1000;
        #1 chk({tag, "_mfhi_busy"}, aluout, cur_hi);
        srca = ~srca;
        srcb = ~srcb;
      end
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({tag, "_latency"}, cycles, 32);
      chk({tag, "_busy_cycles"}, busy_cnt, 32);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
      chk({tag, "_sb_nonempty"}, sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
      end
    end
  endtask

  initial begin
    int dn;
    logic [3:0] op;
    reset_n    = 1'b0;
    start      = 1'b0;
    srca       = '0;
    srcb       = '0;
    alucontrol = '0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    alu_chk("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    alu_chk("sub_eq",  4'b0001, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    alu_chk("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    alu_chk("add_neg", 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    alu_chk("slt",     4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    alu_chk("sltu",    4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    alu_chk("and",     4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
    alu_chk("or",      4'b0011, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1'b0, 1'b0);
    alu_chk("xor",     4'b0110, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
    alu_chk("nor",     4'b0111, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 1'b0, 1'b0);
    alu_chk("op1110",  4'b1110, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1'b0);
    alu_chk("mult_op", 4'b1010, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1'b0);

    @(negedge clk);
    launch(4'b1010, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_m3x5", -1);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFF1);
    alucontrol = 4'b1001;
    #1 chk("mflo_after_mult", aluout, 32'hFFFF_FFF1);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);

    launch(4'b1101, 32'd100, 32'd7);
    wait_done("divu_100_7", -1);
    launch(4'b1100, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 10);
    chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi_const", hi, 32'hFFFF_FFFF);

    launch(4'b1100, 32'h1234_5678, 32'd0);
    wait_done("div_by0", -1);
    launch(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_minneg", -1);
    chk("div_minneg_lo_const", lo, 32'h8000_0000);
    launch(4'b1100, 32'hFFFF_FF00, 32'd0);
    wait_done("div_neg_by0", -1);
    launch(4'b1101, 32'hDEAD_BEEF, 32'd0);
    wait_done("divu_by0", -1);
    launch(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", -1);

    for (int i = 0; i < 6; i++) begin
      op = 4'b1010 + 4'(i % 4);
      launch(op, $urandom, $urandom | 32'd1);
      wait_done("rand", 20);
    end

    @(negedge clk);
    start      = 1'b1;
    alucontrol = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", busy, 1'b0);
    @(negedge clk);
    chk("ignored_start_done", done, 1'b0);

    launch(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    sb_q.delete();
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("midrst_no_done", dn, 0);
    launch(4'b1011, 32'h0001_0003, 32'h0002_0005);
    wait_done("after_rst", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised next-generation datapath ALU for the MIPS core.
- Single-cycle integer ops (add/sub/logic/set-less-than), combinational as before, with signed/unsigned compare and an overflow flag.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake, so the multi-cycle MIPS controller can stall on busy.

Parameters:
WIDTH, 32, datapath width in bits; even, at least 8.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
srca  input  WIDTH  operand A (dividend / multiplicand)
srcb  input  WIDTH  operand B (divisor / multiplier)
alucontrol  input  4  operation select
start  input  1  launch multiply/divide; sampled on clk rising edge
aluout  output  WIDTH  combinational result
zero  output  1  high when aluout is all zeros
overflow  output  1  signed overflow for add/sub; 0 for all other ops
busy  output  1  multiply/divide in progress
done  output  1  one-cycle pulse: HI/LO just updated
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- alucontrol encoding (combinational aluout):
  - 0000 add; 0001 sub; 0010 and; 0011 or.
  - 0100 slt (signed); 0101 sltu; 0110 xor; 0111 nor.
  - 1000 mfhi (aluout = hi); 1001 mflo (aluout = lo).
  - 1010 mult; 1011 multu; 1100 div; 1101 divu; for these four, aluout = 0.
  - 1110, 1111: aluout = 0.
- slt/sltu results are 1 or 0, zero-extended to WIDTH.
- zero = NOR of aluout, all ops.
- overflow: add sets it when operand signs are equal and result sign differs; sub sets it when operand signs differ and result sign differs from srca.
- Reset (async, reset_n low):
  - FSM to IDLE.
  - busy = 0, done = 0, hi = 0, lo = 0, iteration counter = 0.
  - Applies immediately, including mid-operation; the partial result is discarded.
- FSM states:
  - IDLE: a start with alucontrol in 1010..1101 is accepted; operands and op are latched at that edge (E0), next state RUN, busy = 1.
  - IDLE: start with any other code is ignored, no state change.
  - RUN: one radix-2 iteration per edge, edges E1..E_WIDTH.
  - At edge E_WIDTH: hi/lo are written, next state IDLE, busy = 0, done = 1 for exactly one cycle.
- Latency: done is visible WIDTH cycles after the start edge.
- Back-to-back: start accepted in the done cycle (busy = 0).
- start while busy is ignored; operand changes during RUN have no effect.
- Multiply: {hi,lo} = full 2*WIDTH-bit product. Signed ops work on magnitudes; the sign is applied at the final edge.
- Divide: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
- Divide by zero (srcb = 0), signed or unsigned: lo = all ones, hi = srca; same latency; no trap.
- Signed most-negative / -1: lo = most-negative, hi = 0.
- hi/lo hold their old values during RUN. mfhi/mflo during busy return the old values.

Test Plan:
- WIDTH=32, add 0x7FFFFFFF + 0x00000001 -> aluout = 0x80000000, overflow = 1, zero = 0. Then sub 5 - 5 -> aluout = 0, zero = 1, overflow = 0.
- srca = 0xFFFFFFFF, srcb = 1: slt -> aluout = 1; sltu -> aluout = 0, zero = 1.
- mult -3 * 5 with start pulse -> busy high for 32 cycles, done one cycle, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Then mflo -> aluout = 0xFFFFFFF1.
- divu 100 / 7 -> lo = 14, hi = 2. div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Second start in the done cycle is accepted; a start during busy is ignored.
- div 0x12345678 / 0 -> lo = 0xFFFFFFFF, hi = 0x12345678 after 32 cycles. div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- multu started, reset_n pulsed low at iteration 10 -> busy, done, hi, lo = 0 immediately; no done pulse follows; a new start after release completes normally.
